// File: rtl/insq_if.sv
// insq_if: fetch-side and decode-side signals of the dual-issue instruction queue.
interface insq_if #(parameter int PC = 16, parameter int INS = 32, parameter int DEPTH = 8);
    logic                     flush;
    logic [INS-1:0]           f_ins1, f_ins2;
    logic [PC-1:0]            f_pc1, f_pc2;
    logic                     f_v1, f_v2;
    logic                     f_ready;
    logic                     dec_ready;
    logic [INS-1:0]           instruction1, instruction2;
    logic                     ins1_valid, ins2_valid;
    logic [PC-1:0]            PC_in1, PC_in2;
    logic [$clog2(DEPTH):0]   count;
    modport master (
        output flush, f_ins1, f_ins2, f_pc1, f_pc2, f_v1, f_v2, dec_ready,
        input  f_ready, instruction1, instruction2, ins1_valid, ins2_valid, PC_in1, PC_in2, count
    );
    modport slave (
        input  flush, f_ins1, f_ins2, f_pc1, f_pc2, f_v1, f_v2, dec_ready,
        output f_ready, instruction1, instruction2, ins1_valid, ins2_valid, PC_in1, PC_in2, count
    );
endinterface

// File: rtl/insq.sv
// insq: dual-issue instruction queue between fetch and decode.
// Optional INSQ_BYPASS_EN: fetch pair drives the decoder directly when the queue is empty.
module insq #(parameter int PC = 16, parameter int INS = 32, parameter int DEPTH = 8) (
    input logic   clk,
    input logic   rst,
    insq_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [INS-1:0] ins_mem [DEPTH];
    logic [PC-1:0]  pc_mem  [DEPTH];
    logic [AW-1:0]  head, tail, head1;
    logic [CW-1:0]  cnt;
    logic           byp, enq_ok, v1, v2;
    logic [1:0]     n_enq, n_deq;
    logic [INS-1:0] ins_first, ins1, ins2;
    logic [PC-1:0]  pc_first, pc1, pc2;
    assign q.f_ready = cnt <= CW'(DEPTH - 2);
`ifdef INSQ_BYPASS_EN
    assign byp = (cnt == '0) && q.dec_ready && q.f_ready && !q.flush;
`else
    assign byp = 1'b0;
`endif
    // A lone slot-2 instruction is compacted into slot 1 position
    assign ins_first = q.f_v1 ? q.f_ins1 : q.f_ins2;
    assign pc_first  = q.f_v1 ? q.f_pc1  : q.f_pc2;
    assign enq_ok = q.f_ready && !q.flush && !byp;
    assign n_enq  = enq_ok ? {1'b0, q.f_v1} + {1'b0, q.f_v2} : 2'd0;
    assign n_deq  = (q.dec_ready && !q.flush) ? (cnt >= CW'(2) ? 2'd2 : {1'b0, cnt != '0}) : 2'd0;
    assign head1  = head + AW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (q.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(n_deq);
            tail <= tail + AW'(n_enq);
            cnt  <= cnt + CW'(n_enq) - CW'(n_deq);
        end
    end
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            ins_mem[tail] <= ins_first;
            pc_mem[tail]  <= pc_first;
        end
        if (n_enq == 2'd2) begin
            ins_mem[tail + AW'(1)] <= q.f_ins2;
            pc_mem[tail + AW'(1)]  <= q.f_pc2;
        end
    end
    always_comb begin
        v1   = byp ? (q.f_v1 | q.f_v2) : (cnt != '0);
        v2   = byp ? (q.f_v1 & q.f_v2) : (cnt >= CW'(2));
        ins1 = byp ? ins_first : ins_mem[head];
        pc1  = byp ? pc_first  : pc_mem[head];
        ins2 = byp ? q.f_ins2  : ins_mem[head1];
        pc2  = byp ? q.f_pc2   : pc_mem[head1];
    end
    assign q.ins1_valid   = v1;
    assign q.ins2_valid   = v2;
    assign q.instruction1 = v1 ? ins1 : '0;
    assign q.PC_in1       = v1 ? pc1  : '0;
    assign q.instruction2 = v2 ? ins2 : '0;
    assign q.PC_in2       = v2 ? pc2  : '0;
    assign q.count        = cnt;
endmodule
